// File: rtl/stream_demux_1ton_pkg.sv
// Shared definitions for the stream demux/mux family.
// Holds the slot-state encoding and the default geometry constants.
package stream_demux_1ton_pkg;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  localparam int DEF_NUM_CH = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 16;

endpackage

// File: rtl/stream_demux_1ton_slot.sv
// One-entry register slice for a single demux channel.
// A drain and a load in the same cycle keep the slot full, so there is no bubble.
module demux_slot
  import stream_demux_1ton_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic              valid,
  input  logic              ready,
  output logic [DATA_W-1:0] q
);

  slot_state_t state;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SLOT_EMPTY;
      // NOTE: the data register is reset as well, because out_data must read zero after reset.
      q     <= '0;
    end else begin
      if (load) q <= d;
      case (state)
        SLOT_EMPTY: if (load)           state <= SLOT_FULL;
        SLOT_FULL:  if (ready && !load) state <= SLOT_EMPTY;
        default:                        state <= SLOT_EMPTY;
      endcase
    end
  end

  assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demultiplexer with per-channel holding slots.
// Out-of-range unicast words are discarded and counted; broadcast needs every slot free.
module stream_demux_1ton
  import stream_demux_1ton_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int SEL_W  = $clog2(NUM_CH),
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic                     sel_err
);

  logic [NUM_CH-1:0] sel_hot;
  logic [NUM_CH-1:0] slot_free;
  logic [NUM_CH-1:0] load;
  logic              in_range;
  logic              accept;
  logic              drop;

  // Decoding into a one-hot vector avoids indexing with an out-of-range select.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    sel_hot = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      sel_hot[k] = (in_sel == SEL_W'(k));
    end
  end

  assign in_range  = |sel_hot;
  assign slot_free = ~out_valid | out_ready;

  always_comb begin
    in_ready = 1'b1;
    if (in_bcast)      in_ready = &slot_free;
    else if (in_range) in_ready = |(sel_hot & slot_free);
  end

  assign accept = in_valid & in_ready;
  assign drop   = accept & ~in_bcast & ~in_range;

  always_comb begin
    load = '0;
    if (accept) load = in_bcast ? {NUM_CH{1'b1}} : sel_hot;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
      sel_err  <= 1'b0;
    end else begin
      sel_err <= drop;
      if (drop && (drop_cnt != {CNT_W{1'b1}})) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
    demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk  (clk),
      .rst  (rst),
      .load (load[k]),
      .d    (in_data),
      .valid(out_valid[k]),
      .ready(out_ready[k]),
      .q    (out_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Scoreboard bench for stream_demux_1ton: an 8-channel instance for routing and flow control,
// and a 6-channel instance with a 2-bit counter for out-of-range drops and saturation.
module tb_stream_demux_1ton;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;
  localparam int S_CH   = 6;
  localparam int S_CNT  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                     in_valid, in_ready, in_bcast;
  logic [DATA_W-1:0]        in_data;
  logic [SEL_W-1:0]         in_sel;
  logic [NUM_CH-1:0]        out_valid, out_ready;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic [15:0]              drop_cnt;
  logic                     sel_err;

  logic                   s_in_valid, s_in_ready, s_in_bcast;
  logic [DATA_W-1:0]      s_in_data;
  logic [2:0]             s_in_sel;
  logic [S_CH-1:0]        s_out_valid, s_out_ready;
  logic [S_CH*DATA_W-1:0] s_out_data;
  logic [S_CNT-1:0]       s_drop_cnt;
  logic                   s_sel_err;

  stream_demux_1ton #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sel(in_sel), .in_bcast(in_bcast), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .drop_cnt(drop_cnt), .sel_err(sel_err)
  );

  stream_demux_1ton #(.NUM_CH(S_CH), .DATA_W(DATA_W), .SEL_W(3), .CNT_W(S_CNT)) dut_small (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .in_sel(s_in_sel), .in_bcast(s_in_bcast), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .drop_cnt(s_drop_cnt), .sel_err(s_sel_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] exp_q [NUM_CH][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake on a channel must match the oldest word expected there.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          check($sformatf("ch%0d_pending", k), 32'(exp_q[k].size() != 0), 32'd1);
          if (exp_q[k].size() != 0)
            check($sformatf("ch%0d_data", k), 32'(out_data[k*DATA_W +: DATA_W]), 32'(exp_q[k].pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic bcast, input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] d);
    if (bcast) begin
      for (int k = 0; k < NUM_CH; k++) exp_q[k].push_back(d);
    end else begin
      exp_q[sel].push_back(d);
    end
  endtask

  task automatic send(input logic bcast, input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] d,
                      input int budget);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_bcast = bcast;
    in_sel   = sel;
    in_data  = d;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        push_expected(bcast, sel, d);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    in_bcast = 1'b0;
    check("send_accepted", 32'(done), 32'd1);
  endtask

  task automatic s_drop(input logic [2:0] sel, input logic [S_CNT-1:0] exp_cnt);
    s_in_valid = 1'b1;
    s_in_sel   = sel;
    s_in_data  = 8'hEE;
    @(negedge clk);
    check("oor_in_ready", 32'(s_in_ready), 32'd1);
    tick();
    s_in_valid = 1'b0;
    check("oor_sel_err_pulse", 32'(s_sel_err), 32'd1);
    check("oor_drop_cnt", 32'(s_drop_cnt), 32'(exp_cnt));
    check("oor_no_valid", 32'(s_out_valid), 32'd0);
    tick();
    check("oor_sel_err_clear", 32'(s_sel_err), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b1;
    in_bcast    = 1'b0;
    in_sel      = 3'd2;
    in_data     = 8'hFF;
    out_ready   = '1;
    s_in_valid  = 1'b1;
    s_in_bcast  = 1'b0;
    s_in_sel    = 3'd7;
    s_in_data   = 8'hFF;
    s_out_ready = '1;

    // Reset held for three clocks with traffic offered.
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data[31:0], 32'd0);
    check("rst_out_data_hi", out_data[63:32], 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_small_drop_cnt", 32'(s_drop_cnt), 32'd0);
    check("rst_small_sel_err", 32'(s_sel_err), 32'd0);
    tick();
    rst        = 1'b0;
    in_valid   = 1'b0;
    s_in_valid = 1'b0;
    tick();

    // Unicast sweep: each word appears one clock later on its channel alone.
    for (int k = 0; k < NUM_CH; k++) begin
      send(1'b0, SEL_W'(k), 8'(8'hA0 + k), 4);
      check($sformatf("sweep_valid%0d", k), 32'(out_valid), 32'(1 << k));
    end
    tick();
    tick();

    // Backpressure on channel 3 only.
    out_ready = 8'hF7;
    send(1'b0, 3'd3, 8'h31, 4);
    in_valid = 1'b1;
    in_sel   = 3'd3;
    in_data  = 8'h32;
    @(negedge clk);
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk);
    check("bp_stall_ready2", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b0;
    send(1'b0, 3'd5, 8'h55, 4);
    check("bp_ch5_passes", 32'(out_valid), 32'h28);
    fork
      send(1'b0, 3'd3, 8'h32, 6);
      begin
        @(negedge clk);
        check("bp_still_stalled", 32'(in_ready), 32'd0);
        tick();
        out_ready = '1;
      end
    join
    tick();
    tick();

    // Broadcast blocked by a full, stalled slot 6, then released.
    out_ready = 8'hBF;
    send(1'b0, 3'd6, 8'h66, 4);
    in_valid = 1'b1;
    in_bcast = 1'b1;
    in_sel   = 3'd0;
    in_data  = 8'h5A;
    @(negedge clk);
    check("bc_stall_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid  = 1'b0;
    in_bcast  = 1'b0;
    out_ready = '1;
    send(1'b1, 3'd0, 8'h5A, 4);
    check("bc_all_valid", 32'(out_valid), 32'hFF);
    tick();
    tick();

    // Out-of-range drops on the 6-channel instance, then a legal word to its top channel.
    s_drop(3'd6, 2'd1);
    s_drop(3'd7, 2'd2);
    s_drop(3'd6, 2'd3);
    s_drop(3'd7, 2'd3);
    s_drop(3'd6, 2'd3);
    s_in_valid = 1'b1;
    s_in_sel   = 3'd5;
    s_in_data  = 8'h5C;
    @(negedge clk);
    check("small_ch5_ready", 32'(s_in_ready), 32'd1);
    tick();
    s_in_valid = 1'b0;
    check("small_ch5_valid", 32'(s_out_valid), 32'h20);
    check("small_ch5_data", 32'(s_out_data[5*DATA_W +: DATA_W]), 32'h5C);
    check("small_no_err", 32'(s_sel_err), 32'd0);
    tick();

    // Reset in the middle of held traffic flushes the slots and the drop counter.
    out_ready = '0;
    send(1'b0, 3'd1, 8'h11, 4);
    send(1'b0, 3'd2, 8'h22, 4);
    check("flush_pre_valid", 32'(out_valid), 32'h06);
    rst = 1'b1;
    for (int k = 0; k < NUM_CH; k++) exp_q[k].delete();
    #1;
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_out_data", out_data[31:0], 32'd0);
    check("flush_small_drop_cnt", 32'(s_drop_cnt), 32'd0);
    tick();
    rst       = 1'b0;
    out_ready = '1;
    tick();
    check("flush_post_valid", 32'(out_valid), 32'd0);

    // Back-to-back drain and load on one channel sustains a word per clock.
    in_valid = 1'b1;
    in_sel   = 3'd2;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'(8'hC0 + i);
      @(negedge clk);
      check("b2b_ready", 32'(in_ready), 32'd1);
      if (i > 0) check("b2b_valid", 32'(out_valid[2]), 32'd1);
      if (in_ready) push_expected(1'b0, 3'd2, in_data);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Random traffic against the per-channel scoreboard.
    for (int c = 0; c < 2000; c++) begin
      out_ready = 8'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_bcast  = ($urandom_range(0, 7) == 0);
      in_sel    = 3'($urandom);
      in_data   = 8'($urandom);
      @(negedge clk);
      if (in_valid && in_ready) push_expected(in_bcast, in_sel, in_data);
      tick();
    end
    in_valid  = 1'b0;
    in_bcast  = 1'b0;
    out_ready = '1;
    repeat (4) tick();
    for (int k = 0; k < NUM_CH; k++)
      check($sformatf("final_q%0d_empty", k), 32'(exp_q[k].size()), 32'd0);
    check("final_out_valid", 32'(out_valid), 32'd0);
    check("final_drop_cnt", 32'(drop_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
